// File: rtl/apb_tach_if.sv
// APB completer bundle for the fan tachometer monitor.
interface apb_tach_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [9:0]  paddr;
  logic [15:0] pwdata;
  logic        pready;
  logic [15:0] prdata;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_tach_monitor.sv
// Fan tach edge counter with gated RPM, stall and threshold alarms.
module apb_tach_monitor #(
  parameter int NUM_CHANNELS = 4,
  parameter int REFCLK_HZ    = 250000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CHANNELS-1:0] tach,
  apb_tach_if.slave               apb,
  output logic                    irq
);
  localparam int N   = NUM_CHANNELS;
  localparam int WIN = REFCLK_HZ / 2;
  localparam int GW  = (WIN > 1) ? $clog2(WIN) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic [GW-1:0] gate;
  logic          win_end;
  logic [N-1:0]  s1, s2, s3, rise;
  logic [15:0]   edges   [N];
  logic [15:0]   total   [N];
  logic [21:0]   prod    [N];
  logic [15:0]   rpm_new [N];
  logic [15:0]   rpm     [N];
  logic [15:0]   thresh  [N];
  logic [N-1:0]  stall, status, irq_en;
  logic [N-1:0]  alarm, clr;
  logic [15:0]   windows;
  logic [15:0]   rd;
  logic          hit, ro, err, wr;

  assign win_end = (gate == GW'(WIN - 1));
  assign rise    = s2 & ~s3;

  // An edge landing on the wrap cycle still belongs to the closing window.
  always_comb begin
    alarm = '0;
    for (int i = 0; i < N; i++) begin
      total[i] = (rise[i] && edges[i] != 16'hffff)
               ? edges[i] + 16'd1 : edges[i];
      prod[i]    = 22'(total[i]) * 22'd60;
      rpm_new[i] = (prod[i] > 22'h00ffff)
                 ? 16'hffff : prod[i][15:0];
      alarm[i]   = win_end && (thresh[i] != 16'd0)
                 && (rpm_new[i] < thresh[i]);
    end
  end

  always_comb begin
    rd  = '0;
    hit = 1'b0;
    ro  = 1'b0;
    case (apb.paddr)
      10'h000: begin rd = 16'(irq_en); hit = 1'b1; end
      10'h002: begin rd = 16'(status); hit = 1'b1; end
      10'h004: begin
        rd = 16'(stall); hit = 1'b1; ro = 1'b1;
      end
      10'h006: begin
        rd = windows; hit = 1'b1; ro = 1'b1;
      end
      default: ;
    endcase
    for (int i = 0; i < N; i++) begin
      if (apb.paddr == 10'(32 + 2 * i)) begin
        rd = rpm[i]; hit = 1'b1; ro = 1'b1;
      end
      if (apb.paddr == 10'(64 + 2 * i)) begin
        rd = thresh[i]; hit = 1'b1;
      end
    end
  end

  assign err = !hit || (apb.pwrite && ro);
  assign wr  = (state == ACCESS) && apb.psel
            && apb.pwrite && !err;
  assign clr = (wr && apb.paddr == 10'h002)
             ? apb.pwdata[N-1:0] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate    <= '0;
      s1      <= '0;
      s2      <= '0;
      s3      <= '0;
      stall   <= '1;
      status  <= '0;
      windows <= '0;
      for (int i = 0; i < N; i++) begin
        edges[i] <= '0;
        rpm[i]   <= '0;
      end
    end else begin
      s1     <= tach;
      s2     <= s1;
      s3     <= s2;
      gate   <= win_end ? '0 : gate + GW'(1);
      status <= (status & ~clr) | alarm;
      if (win_end) windows <= windows + 16'd1;
      for (int i = 0; i < N; i++) begin
        edges[i] <= win_end ? 16'd0 : total[i];
        if (win_end) begin
          rpm[i]   <= rpm_new[i];
          stall[i] <= (total[i] == 16'd0);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq    <= 1'b0;
      irq_en <= '0;
      for (int i = 0; i < N; i++) thresh[i] <= '0;
    end else begin
      irq <= |(status & irq_en);
      if (wr && apb.paddr == 10'h000)
        irq_en <= apb.pwdata[N-1:0];
      for (int i = 0; i < N; i++)
        if (wr && apb.paddr == 10'(64 + 2 * i))
          thresh[i] <= apb.pwdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      apb.pready  <= 1'b0;
      apb.prdata  <= '0;
      apb.pslverr <= 1'b0;
    end else begin
      apb.pready  <= 1'b0;
      apb.prdata  <= '0;
      apb.pslverr <= 1'b0;
      unique case (state)
        IDLE:
          if (apb.psel && apb.penable) state <= ACCESS;
        ACCESS:
          if (apb.psel) begin
            state       <= RESP;
            apb.pready  <= 1'b1;
            apb.pslverr <= err;
            apb.prdata  <= (err || apb.pwrite) ? '0 : rd;
          end else begin
            state <= IDLE;
          end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_tach_monitor.sv
// Scoreboard bench for apb_tach_monitor: window timing, alarms, errors, reset.
module tb_apb_tach_monitor;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic [3:0] tach_a = '0;
  logic [0:0] tach_b = '0;
  logic       irq_a, irq_b;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [26:0] exp_q [$];
  logic [26:0] mon_e;

  apb_tach_if m ();
  apb_tach_if bus_a ();
  apb_tach_if bus_b ();

  always #5 clk = ~clk;

  assign bus_a.psel    = m.psel & ~sel;
  assign bus_a.penable = m.penable;
  assign bus_a.pwrite  = m.pwrite;
  assign bus_a.paddr   = m.paddr;
  assign bus_a.pwdata  = m.pwdata;
  assign bus_b.psel    = m.psel & sel;
  assign bus_b.penable = m.penable;
  assign bus_b.pwrite  = m.pwrite;
  assign bus_b.paddr   = m.paddr;
  assign bus_b.pwdata  = m.pwdata;
  assign m.pready  = sel ? bus_b.pready  : bus_a.pready;
  assign m.prdata  = sel ? bus_b.prdata  : bus_a.prdata;
  assign m.pslverr = sel ? bus_b.pslverr : bus_a.pslverr;

  apb_tach_monitor #(.NUM_CHANNELS(4), .REFCLK_HZ(1000)) u_dut (
    .clk(clk), .rst(rst), .tach(tach_a), .apb(bus_a), .irq(irq_a)
  );

  apb_tach_monitor #(.NUM_CHANNELS(1), .REFCLK_HZ(5000)) u_sat (
    .clk(clk), .rst(rst), .tach(tach_b), .apb(bus_b), .irq(irq_b)
  );

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // Tach patterns keyed to cycles since the last reset release.
  initial forever begin
    @(negedge clk);
    #1;
    if (rst) begin
      tach_a = '0;
      tach_b = '0;
    end else begin
      tach_a[0] = (cyc % 20) >= 10;
      tach_a[1] = 1'b0;
      tach_a[2] = (cyc % 2) == 0;
      tach_a[3] = (cyc >= 1997) && (cyc < 2002);
      tach_b[0] = (cyc % 2) == 0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (m.pready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected data %h err %b",
                 m.prdata, m.pslverr);
      end else begin
        mon_e = exp_q.pop_front();
        if (m.prdata !== mon_e[16:1] || m.pslverr !== mon_e[0]) begin
          errors++;
          $display("FAIL resp addr %h got %h/%b want %h/%b",
                   mon_e[26:17], m.prdata, m.pslverr,
                   mon_e[16:1], mon_e[0]);
        end
      end
    end else if (!rst) begin
      checks++;
      if (m.prdata !== 16'h0 || m.pslverr !== 1'b0) begin
        errors++;
        $display("FAIL idle_bus got %h/%b want 0000/0",
                 m.prdata, m.pslverr);
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (cyc != n) begin
      errors++;
      $display("FAIL wait_cyc got %0d want %0d", cyc, n);
    end
  endtask

  task automatic xfer(input logic w, input logic [9:0] a,
                      input logic [15:0] d, input logic [15:0] ed,
                      input logic ee);
    int lat = 0;
    exp_q.push_back({a, ed, ee});
    @(negedge clk);
    m.psel = 1'b1; m.pwrite = w; m.paddr = a;
    m.pwdata = d; m.penable = 1'b0;
    @(negedge clk);
    m.penable = 1'b1;
    do begin
      @(negedge clk);
      lat++;
    end while (!m.pready && lat < 8);
    m.psel = 1'b0; m.penable = 1'b0; m.pwrite = 1'b0;
    chk("latency", 16'(lat), 16'd2);
  endtask

  task automatic rd(input logic [9:0] a, input logic [15:0] ed,
                    input logic ee);
    xfer(1'b0, a, 16'h0, ed, ee);
  endtask

  task automatic wr(input logic [9:0] a, input logic [15:0] d,
                    input logic ee);
    xfer(1'b1, a, d, 16'h0, ee);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    m.psel = 1'b0; m.penable = 1'b0; m.pwrite = 1'b0;
    m.paddr = '0;  m.pwdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_pready", 16'(m.pready), 16'h0);
    chk("rst_prdata", m.prdata, 16'h0);
    chk("rst_irq", 16'(irq_a), 16'h0);
    rst = 1'b0;

    rd(10'h004, 16'h000f, 1'b0);
    rd(10'h006, 16'h0000, 1'b0);
    rd(10'h020, 16'h0000, 1'b0);
    rd(10'h002, 16'h0000, 1'b0);
    wr(10'h042, 16'd100, 1'b0);
    wr(10'h040, 16'd1000, 1'b0);
    wr(10'h044, 16'd14940, 1'b0);
    wr(10'h000, 16'hfff2, 1'b0);
    rd(10'h000, 16'h0002, 1'b0);
    rd(10'h042, 16'd100, 1'b0);
    rd(10'h010, 16'h0000, 1'b1);
    rd(10'h003, 16'h0000, 1'b1);
    wr(10'h020, 16'h1234, 1'b1);
    wr(10'h006, 16'h0005, 1'b1);
    rd(10'h048, 16'h0000, 1'b1);

    // Abandoned write: psel drops while the FSM sits in ACCESS.
    @(negedge clk);
    m.psel = 1'b1; m.pwrite = 1'b1; m.paddr = 10'h000;
    m.pwdata = 16'h0000; m.penable = 1'b0;
    @(negedge clk);
    m.penable = 1'b1;
    @(negedge clk);
    m.psel = 1'b0; m.penable = 1'b0; m.pwrite = 1'b0;
    repeat (4) @(negedge clk);
    rd(10'h000, 16'h0002, 1'b0);

    wait_cyc(500);
    chk("irq_w1_early", 16'(irq_a), 16'h0);
    @(negedge clk);
    chk("irq_w1", 16'(irq_a), 16'h1);
    rd(10'h020, 16'd1500, 1'b0);
    rd(10'h022, 16'd0, 1'b0);
    rd(10'h024, 16'd14940, 1'b0);
    rd(10'h026, 16'd0, 1'b0);
    rd(10'h004, 16'h000a, 1'b0);
    rd(10'h006, 16'd1, 1'b0);
    rd(10'h002, 16'h0002, 1'b0);
    wr(10'h002, 16'h0002, 1'b0);
    chk("irq_hold", 16'(irq_a), 16'h1);
    @(negedge clk);
    chk("irq_clr", 16'(irq_a), 16'h0);
    rd(10'h002, 16'h0000, 1'b0);

    wait_cyc(1000);
    chk("irq_w2_early", 16'(irq_a), 16'h0);
    @(negedge clk);
    chk("irq_w2", 16'(irq_a), 16'h1);
    rd(10'h024, 16'd15000, 1'b0);
    rd(10'h020, 16'd1500, 1'b0);
    rd(10'h006, 16'd2, 1'b0);
    rd(10'h002, 16'h0002, 1'b0);

    // Clear lands on the same edge that re-sets the alarm.
    wait_cyc(1496);
    wr(10'h002, 16'h0002, 1'b0);
    rd(10'h002, 16'h0002, 1'b0);
    chk("irq_setwins", 16'(irq_a), 16'h1);

    wait_cyc(2001);
    rd(10'h026, 16'd60, 1'b0);
    rd(10'h004, 16'h0002, 1'b0);
    rd(10'h006, 16'd4, 1'b0);
    wait_cyc(2501);
    rd(10'h026, 16'd0, 1'b0);
    rd(10'h004, 16'h000a, 1'b0);
    rd(10'h006, 16'd5, 1'b0);

    wait_cyc(2747);
    @(negedge clk);
    m.psel = 1'b1; m.pwrite = 1'b0; m.paddr = 10'h006;
    m.penable = 1'b0;
    @(negedge clk);
    m.penable = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    m.psel = 1'b0; m.penable = 1'b0;
    #1;
    chk("midrst_irq", 16'(irq_a), 16'h0);
    chk("midrst_pready", 16'(m.pready), 16'h0);
    chk("midrst_prdata", m.prdata, 16'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    rd(10'h000, 16'h0000, 1'b0);
    rd(10'h002, 16'h0000, 1'b0);
    rd(10'h042, 16'h0000, 1'b0);
    rd(10'h020, 16'h0000, 1'b0);
    rd(10'h004, 16'h000f, 1'b0);
    rd(10'h006, 16'h0000, 1'b0);
    wr(10'h042, 16'd100, 1'b0);
    wr(10'h000, 16'h0002, 1'b0);
    wait_cyc(496);
    rd(10'h020, 16'h0000, 1'b0);
    chk("irq_rw_early", 16'(irq_a), 16'h0);
    @(negedge clk);
    chk("irq_rw", 16'(irq_a), 16'h1);
    rd(10'h020, 16'd1500, 1'b0);
    rd(10'h006, 16'd1, 1'b0);

    wait_cyc(2503);
    sel = 1'b1;
    rd(10'h020, 16'hffff, 1'b0);
    rd(10'h004, 16'h0000, 1'b0);
    rd(10'h006, 16'd1, 1'b0);
    rd(10'h022, 16'h0000, 1'b1);
    wr(10'h000, 16'hffff, 1'b0);
    rd(10'h000, 16'h0001, 1'b0);
    sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("sat_irq", 16'(irq_b), 16'h0);
    chk("queue_empty", 16'(exp_q.size()), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
